muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter ITERATIONS, default 32, meaning the number of radix-2 iteration cycles per operation.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the operand and HI/LO width.
REQ-003 SHALL have input CLK, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have input RESET, 1 bit, the reset; it is synchronous and active-low.
REQ-005 SHALL have input FLUSH, 1 bit, which aborts the in-flight operation.
REQ-006 SHALL have input Start_IN, 1 bit, a multiply/divide request from EXE.
REQ-007 SHALL have input Op_IN, 2 bits: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
REQ-008 SHALL have inputs OperandA_IN and OperandB_IN, DATA_W bits each, the post-forwarding operands.
REQ-009 SHALL have input HiLoRead_IN, 1 bit, asserted when the EXE instruction is MFHI/MFLO.
REQ-010 SHALL have inputs WriteHI_IN and WriteLO_IN, 1 bit each, plus WriteData_IN, DATA_W bits, for MTHI/MTLO.
REQ-011 SHALL have outputs HI_OUT and LO_OUT, DATA_W bits each, the architectural HI/LO registers.
REQ-012 SHALL have output Busy_OUT, 1 bit, high while the FSM is not IDLE.
REQ-013 SHALL have output Stall_OUT, 1 bit, combinational, the pipeline hold request to IF/ID/EXE.
REQ-014 SHALL have output Done_OUT, 1 bit, a one-cycle pulse on HI/LO commit.

Function
REQ-015 SHALL implement the FSM states IDLE, CALC and FIXUP.
REQ-016 SHALL, in IDLE with Start_IN=1, latch |A| and |B| (signed ops) or raw values (unsigned ops), latch the result-sign flags, clear the iteration counter and enter CALC.
REQ-017 SHALL, in CALC, perform one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, increment the counter, and enter FIXUP when the counter reaches ITERATIONS-1.
REQ-018 SHALL, in FIXUP, apply sign correction, write HI/LO, pulse Done_OUT and return to IDLE.
REQ-019 SHALL take ITERATIONS+2 rising edges from the Start acceptance edge to the HI/LO commit edge (34 at default).
REQ-020 SHALL produce HI:LO = 64-bit product for MULT/MULTU.
REQ-021 SHALL produce LO=quotient and HI=remainder for DIV/DIVU; the remainder takes the dividend's sign.
REQ-022 SHALL, on divide by zero, skip CALC, enter FIXUP next edge, and commit LO=all-ones and HI=OperandA_IN.
REQ-023 SHALL assert Stall_OUT when Busy_OUT=1 and (Start_IN or HiLoRead_IN or WriteHI_IN or WriteLO_IN) is high; the request is not accepted that cycle.
REQ-024 SHALL accept a Start_IN presented in the same cycle as Done_OUT without a stall.
REQ-025 SHALL apply WriteHI_IN/WriteLO_IN only in IDLE with Stall_OUT=0; when Start_IN and a write are both high in IDLE, the write applies and the operation starts.
REQ-026 SHALL, on FLUSH=1 in any state, return to IDLE next edge with HI/LO unchanged and no Done_OUT; FLUSH has priority over Start_IN.
REQ-027 SHALL keep HI_OUT/LO_OUT stable except at the FIXUP commit, MTHI/MTLO and reset.

Reset
REQ-028 SHALL, when RESET=0 at a rising edge, clear HI_OUT, LO_OUT, the counter and all operand registers, set Busy_OUT=0 and Done_OUT=0, and enter IDLE, including mid-operation.
REQ-029 SHALL hold Stall_OUT=0 while RESET=0.

Structure
REQ-030 SHALL take the Op encodings, state encodings and ITERATIONS default from the shared config include, not from local literals.
REQ-031 SHALL place the one-step add/subtract and shift datapath in one sub-module, muldiv_step; the FSM, counter and HI/LO registers stay in muldiv_ctrl.

Verification
REQ-032 SHALL cover MULTU A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE, with Done_OUT on edge 34 after acceptance.
REQ-033 SHALL cover MULT A=-3, B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-034 SHALL cover DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; and DIVU A=9, B=0 -> LO=0xFFFFFFFF, HI=0x00000009 two edges after acceptance.
REQ-035 SHALL cover HiLoRead_IN asserted 5 cycles after a MULT start -> Stall_OUT=1 until Done_OUT, then 0, with the new HI/LO visible.
REQ-036 SHALL cover FLUSH at iteration 10 of DIVU 100/7 preceded by MTLO 0x1234 -> IDLE next edge, LO=0x1234, no Done_OUT; RESET=0 mid-CALC -> HI=LO=0, Busy_OUT=0.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared configuration for the multiply/divide unit: operation codes,
// FSM state encodings and default sizing.
package muldiv_ctrl_pkg;

  localparam int unsigned MD_ITERATIONS = 32;
  localparam int unsigned MD_DATA_W     = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Pipeline-facing bundle of the multiply/divide unit: EXE requests,
// HI/LO move traffic and the architectural HI/LO/status outputs.
interface muldiv_ctrl_if
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = MD_DATA_W
);

  logic              FLUSH;
  logic              Start_IN;
  logic [1:0]        Op_IN;
  logic [DATA_W-1:0] OperandA_IN;
  logic [DATA_W-1:0] OperandB_IN;
  logic              HiLoRead_IN;
  logic              WriteHI_IN;
  logic              WriteLO_IN;
  logic [DATA_W-1:0] WriteData_IN;
  logic [DATA_W-1:0] HI_OUT;
  logic [DATA_W-1:0] LO_OUT;
  logic              Busy_OUT;
  logic              Stall_OUT;
  logic              Done_OUT;

  // Pipeline side: issues requests, observes HI/LO and status.
  modport master (
    output FLUSH, Start_IN, Op_IN, OperandA_IN, OperandB_IN,
    output HiLoRead_IN, WriteHI_IN, WriteLO_IN, WriteData_IN,
    input  HI_OUT, LO_OUT, Busy_OUT, Stall_OUT, Done_OUT
  );

  // Unit side: consumes requests, owns HI/LO and status.
  modport slave (
    input  FLUSH, Start_IN, Op_IN, OperandA_IN, OperandB_IN,
    input  HiLoRead_IN, WriteHI_IN, WriteLO_IN, WriteData_IN,
    output HI_OUT, LO_OUT, Busy_OUT, Stall_OUT, Done_OUT
  );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract
// for divide. acc holds the partial product high half / partial remainder,
// lo holds the multiplier being consumed / dividend bits shifting into quotient.
module muldiv_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              div_i,
  input  logic [DATA_W:0]   acc_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic [DATA_W-1:0] opb_i,
  output logic [DATA_W:0]   acc_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] shifted;
  logic [DATA_W:0] divisor;
  logic [DATA_W:0] diff;

  // Combinational step; acc is one bit wider so 2*rem+bit never overflows.
  always_comb begin
    divisor = {1'b0, opb_i};
    sum     = acc_i + (lo_i[0] ? divisor : '0);
    shifted = {acc_i[DATA_W-1:0], lo_i[DATA_W-1]};
    diff    = shifted - divisor;
    acc_o   = '0;
    lo_o    = '0;
    if (div_i) begin
      if (shifted >= divisor) begin
        acc_o = diff;
        lo_o  = {lo_i[DATA_W-2:0], 1'b1};
      end else begin
        acc_o = shifted;
        lo_o  = {lo_i[DATA_W-2:0], 1'b0};
      end
    end else begin
      acc_o = {1'b0, sum[DATA_W:1]};
      lo_o  = {sum[0], lo_i[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative HI/LO multiply/divide unit: IDLE/CALC/FIXUP FSM, iteration
// counter, operand/sign latches, architectural HI/LO and pipeline stall.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned ITERATIONS = MD_ITERATIONS,
  parameter int unsigned DATA_W     = MD_DATA_W
) (
  input logic          CLK,
  input logic          RESET,
  muldiv_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERATIONS - 1);

  md_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W:0]     acc_q, acc_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [DATA_W-1:0]   opb_q, opb_d;
  logic                div_q, div_d;
  logic                dz_q, dz_d;
  logic                neg_q, neg_d;
  logic                rneg_q, rneg_d;
  logic [DATA_W-1:0]   hireg_q, hireg_d;
  logic [DATA_W-1:0]   loreg_q, loreg_d;
  logic                done_q, done_d;

  md_op_e              op;
  logic                op_div;
  logic                op_sgn;
  logic                a_neg;
  logic                b_neg;
  logic [DATA_W-1:0]   a_abs;
  logic [DATA_W-1:0]   b_abs;
  logic                busy;
  logic [DATA_W:0]     step_acc;
  logic [DATA_W-1:0]   step_lo;
  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;

  assign op     = md_op_e'(bus.Op_IN);
  assign op_div = (op == OP_DIV) || (op == OP_DIVU);
  assign op_sgn = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg  = op_sgn && bus.OperandA_IN[DATA_W-1];
  assign b_neg  = op_sgn && bus.OperandB_IN[DATA_W-1];
  assign a_abs  = a_neg ? (~bus.OperandA_IN + 1'b1) : bus.OperandA_IN;
  assign b_abs  = b_neg ? (~bus.OperandB_IN + 1'b1) : bus.OperandB_IN;

  assign prod     = {acc_q[DATA_W-1:0], lo_q};
  assign prod_fix = neg_q  ? (~prod + 1'b1) : prod;
  assign quo_fix  = neg_q  ? (~lo_q + 1'b1) : lo_q;
  assign rem_fix  = rneg_q ? (~acc_q[DATA_W-1:0] + 1'b1) : acc_q[DATA_W-1:0];

  assign busy          = (state_q != ST_IDLE);
  assign bus.Busy_OUT  = busy;
  assign bus.Done_OUT  = done_q;
  assign bus.HI_OUT    = hireg_q;
  assign bus.LO_OUT    = loreg_q;
  assign bus.Stall_OUT = RESET && busy &&
                         (bus.Start_IN || bus.HiLoRead_IN || bus.WriteHI_IN || bus.WriteLO_IN);

  muldiv_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .div_i (div_q),
    .acc_i (acc_q),
    .lo_i  (lo_q),
    .opb_i (opb_q),
    .acc_o (step_acc),
    .lo_o  (step_lo)
  );

  // Next-state and datapath control; FLUSH overrides every state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    opb_d   = opb_q;
    div_d   = div_q;
    dz_d    = dz_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    hireg_d = hireg_q;
    loreg_d = loreg_q;
    done_d  = 1'b0;
    if (bus.FLUSH) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.WriteHI_IN) hireg_d = bus.WriteData_IN;
          if (bus.WriteLO_IN) loreg_d = bus.WriteData_IN;
          if (bus.Start_IN) begin
            cnt_d  = '0;
            acc_d  = '0;
            div_d  = op_div;
            dz_d   = op_div && (bus.OperandB_IN == '0);
            neg_d  = a_neg ^ b_neg;
            rneg_d = op_div && a_neg;
            opb_d  = op_div ? b_abs : a_abs;
            lo_d   = op_div ? a_abs : b_abs;
            // Divide by zero keeps the raw dividend for the HI commit.
            if (op_div && (bus.OperandB_IN == '0)) begin
              lo_d    = bus.OperandA_IN;
              state_d = ST_FIXUP;
            end else begin
              state_d = ST_CALC;
            end
          end
        end
        ST_CALC: begin
          acc_d = step_acc;
          lo_d  = step_lo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = ST_FIXUP;
        end
        ST_FIXUP: begin
          if (dz_q) begin
            hireg_d = lo_q;
            loreg_d = '1;
          end else if (div_q) begin
            hireg_d = rem_fix;
            loreg_d = quo_fix;
          end else begin
            hireg_d = prod_fix[2*DATA_W-1:DATA_W];
            loreg_d = prod_fix[DATA_W-1:0];
          end
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, operand and HI/LO registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      hireg_q <= '0;
      loreg_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      div_q   <= div_d;
      dz_q    <= dz_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      hireg_q <= hireg_d;
      loreg_q <= loreg_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: expected {HI,LO} pushed at request
// time, popped and compared when Done_OUT pulses.
module tb_muldiv_ctrl;

  logic CLK = 1'b0;
  logic RESET;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  logic [63:0] exp_q[$];

  muldiv_ctrl_if #(.DATA_W(32)) bus ();

  muldiv_ctrl #(
    .ITERATIONS (32),
    .DATA_W     (32)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    res = '0;
    case (op)
      2'd0: res = 64'(sa * sb);
      2'd1: res = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Presents a request to an idle unit; returns after the acceptance edge.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit push);
    bus.Start_IN    = 1'b1;
    bus.Op_IN       = op;
    bus.OperandA_IN = a;
    bus.OperandB_IN = b;
    if (push) exp_q.push_back(model(op, a, b));
    step(1);
    bus.Start_IN = 1'b0;
    check_eq("busy_after_start", bus.Busy_OUT, 1);
  endtask

  // Counts edges inclusive of the acceptance edge until Done_OUT.
  task automatic wait_done(output int edges);
    edges = 1;
    while (!bus.Done_OUT && edges < 200) begin
      step(1);
      edges++;
    end
  endtask

  task automatic pop_compare(input string tag);
    logic [63:0] e;
    if (!bus.Done_OUT) begin
      check_eq({tag, "_timeout"}, 0, 1);
    end else if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, "_hi"}, bus.HI_OUT, e[63:32]);
      check_eq({tag, "_lo"}, bus.LO_OUT, e[31:0]);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int edges;
    start_op(op, a, b, 1'b1);
    wait_done(edges);
    check_eq({tag, "_latency"}, edges, (op[1] && b == 32'd0) ? 2 : 34);
    pop_compare(tag);
    step(1);
    check_eq({tag, "_done_pulse"}, bus.Done_OUT, 0);
  endtask

  initial begin
    int edges;
    int done_seen;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    RESET            = 1'b0;
    bus.FLUSH        = 1'b0;
    bus.Start_IN     = 1'b0;
    bus.Op_IN        = 2'd0;
    bus.OperandA_IN  = '0;
    bus.OperandB_IN  = '0;
    bus.HiLoRead_IN  = 1'b0;
    bus.WriteHI_IN   = 1'b0;
    bus.WriteLO_IN   = 1'b0;
    bus.WriteData_IN = '0;

    step(3);
    check_eq("rst_hi", bus.HI_OUT, 0);
    check_eq("rst_lo", bus.LO_OUT, 0);
    check_eq("rst_busy", bus.Busy_OUT, 0);
    check_eq("rst_done", bus.Done_OUT, 0);
    check_eq("rst_stall", bus.Stall_OUT, 0);
    RESET = 1'b1;
    step(1);

    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'd2);
    run_op("mult_neg", 2'd0, -32'sd3, 32'd5);
    run_op("div_neg", 2'd2, -32'sd7, 32'd2);
    run_op("divu_zero", 2'd3, 32'd9, 32'd0);
    run_op("div_zero_neg", 2'd2, -32'sd5, 32'd0);
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("mult_minneg", 2'd0, 32'h8000_0000, 32'h8000_0000);

    for (int i = 0; i < 12; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 5 == 4) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)));
      run_op("rand", rop, ra, rb);
    end

    // MFHI/MFLO five cycles into a MULT holds the pipeline until Done.
    start_op(2'd0, 32'd1234567, -32'sd89, 1'b1);
    step(4);
    bus.HiLoRead_IN = 1'b1;
    #1;
    edges = 0;
    while (!bus.Done_OUT && edges < 100) begin
      check_eq("hiloread_stall", bus.Stall_OUT, 1);
      step(1);
      edges++;
    end
    check_eq("hiloread_release", bus.Stall_OUT, 0);
    pop_compare("hiloread");
    bus.HiLoRead_IN = 1'b0;
    step(1);

    // Start held during busy is stalled, then accepted in the Done cycle.
    start_op(2'd3, 32'd1000, 32'd7, 1'b1);
    bus.Start_IN    = 1'b1;
    bus.Op_IN       = 2'd1;
    bus.OperandA_IN = 32'h1234_5678;
    bus.OperandB_IN = 32'h9ABC_DEF0;
    exp_q.push_back(model(2'd1, 32'h1234_5678, 32'h9ABC_DEF0));
    #1;
    edges = 0;
    while (!bus.Done_OUT && edges < 100) begin
      check_eq("b2b_stall", bus.Stall_OUT, 1);
      step(1);
      edges++;
    end
    check_eq("b2b_done_stall", bus.Stall_OUT, 0);
    pop_compare("b2b_first");
    step(1);
    bus.Start_IN = 1'b0;
    check_eq("b2b_busy", bus.Busy_OUT, 1);
    wait_done(edges);
    check_eq("b2b_latency", edges, 34);
    pop_compare("b2b_second");
    step(1);

    // MTHI/MTLO then FLUSH at iteration 10 of DIVU 100/7.
    bus.WriteHI_IN   = 1'b1;
    bus.WriteData_IN = 32'hCAFE_0000;
    step(1);
    bus.WriteHI_IN   = 1'b0;
    bus.WriteLO_IN   = 1'b1;
    bus.WriteData_IN = 32'h0000_1234;
    step(1);
    bus.WriteLO_IN = 1'b0;
    check_eq("mthi", bus.HI_OUT, 32'hCAFE_0000);
    check_eq("mtlo", bus.LO_OUT, 32'h0000_1234);
    start_op(2'd3, 32'd100, 32'd7, 1'b0);
    step(10);
    bus.FLUSH = 1'b1;
    step(1);
    bus.FLUSH = 1'b0;
    check_eq("flush_busy", bus.Busy_OUT, 0);
    check_eq("flush_lo", bus.LO_OUT, 32'h0000_1234);
    check_eq("flush_hi", bus.HI_OUT, 32'hCAFE_0000);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.Done_OUT) done_seen++;
      step(1);
    end
    check_eq("flush_no_done", done_seen, 0);
    check_eq("flush_lo_hold", bus.LO_OUT, 32'h0000_1234);

    // FLUSH wins over a simultaneous Start.
    bus.FLUSH    = 1'b1;
    bus.Start_IN = 1'b1;
    bus.Op_IN    = 2'd0;
    step(1);
    bus.FLUSH    = 1'b0;
    bus.Start_IN = 1'b0;
    check_eq("flush_prio_busy", bus.Busy_OUT, 0);

    // Reset mid-CALC clears everything and suppresses the stall.
    start_op(2'd0, 32'd123, 32'd456, 1'b0);
    step(5);
    RESET           = 1'b0;
    bus.HiLoRead_IN = 1'b1;
    #1;
    check_eq("rst_mid_busy_pre", bus.Busy_OUT, 1);
    check_eq("rst_mid_stall", bus.Stall_OUT, 0);
    step(1);
    check_eq("rst_mid_hi", bus.HI_OUT, 0);
    check_eq("rst_mid_lo", bus.LO_OUT, 0);
    check_eq("rst_mid_busy", bus.Busy_OUT, 0);
    check_eq("rst_mid_done", bus.Done_OUT, 0);
    RESET           = 1'b1;
    bus.HiLoRead_IN = 1'b0;
    step(1);

    run_op("post_rst", 2'd2, 32'd100, -32'sd7);
    check_eq("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
